// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core and its SQI memory link.
package idli_pkg;

  typedef logic [3:0] slice_t;

  localparam logic [7:0] SQI_INSTR_READ  = 8'h03;
  localparam logic [7:0] SQI_INSTR_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    INSTR,
    ADDR,
    DUMMY,
    RD_DATA,
    WR_DATA,
    IGNORE
  } sqi_sram_state_t;

endpackage

// File: rtl/idli_sqi_sram_ram_m.sv
// Single-port byte RAM with synchronous read backing the SQI SRAM model.
module idli_sqi_sram_ram_m #(
  parameter int    ADDR_W    = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/idli_sqi_sram_m.sv
// SQI SRAM responder: one 4-bit lane of a sequential-mode serial SRAM,
// oversampling SCK/CS in the GCK domain.
module idli_sqi_sram_m
  import idli_pkg::*;
#(
  parameter int    ADDR_W    = 16,
  parameter string INIT_FILE = ""
) (
  input  logic   i_sqi_gck,
  input  logic   i_sqi_rst,
  input  logic   i_sqi_sck,
  input  logic   i_sqi_cs,
  input  slice_t i_sqi_sio,
  output slice_t o_sqi_sio,
  output logic   o_sqi_sio_oe
);

  sqi_sram_state_t state;

  logic              sck_q;
  logic [1:0]        cnt;
  logic [15:0]       addr;
  slice_t            hold;
  logic              is_rd;

  logic              rise;
  logic              fall;
  logic [15:0]       addr_shift;
  logic [7:0]        instr;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata;

  assign rise       = i_sqi_sck && !sck_q;
  assign fall       = !i_sqi_sck && sck_q;
  assign addr_shift = {addr[11:0], i_sqi_sio};
  assign instr      = {hold, i_sqi_sio};
  assign ptr        = addr[ADDR_W-1:0];
  assign ptr_inc    = ptr + {{(ADDR_W-1){1'b0}}, 1'b1};

  // CS high masks every array access, so a CS rise racing an edge is inert
  assign ram_we = !i_sqi_cs && state == WR_DATA && rise && cnt[0];

  assign ram_re = !i_sqi_cs &&
                  ((state == ADDR && rise && cnt == 2'd3) ||
                   (state == RD_DATA && fall && cnt[0]));

  always_comb begin
    ram_addr = ptr;
    if (state == ADDR)
      ram_addr = addr_shift[ADDR_W-1:0];
    else if (state == RD_DATA)
      ram_addr = ptr_inc;
  end

  idli_sqi_sram_ram_m #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (i_sqi_gck),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (instr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      state        <= IDLE;
      sck_q        <= 1'b0;
      cnt          <= 2'd0;
      addr         <= 16'h0000;
      hold         <= 4'h0;
      is_rd        <= 1'b0;
      o_sqi_sio    <= 4'h0;
      o_sqi_sio_oe <= 1'b0;
    end else begin
      sck_q <= i_sqi_sck;
      if (i_sqi_cs) begin
        state        <= IDLE;
        cnt          <= 2'd0;
        addr         <= 16'h0000;
        hold         <= 4'h0;
        is_rd        <= 1'b0;
        o_sqi_sio    <= 4'h0;
        o_sqi_sio_oe <= 1'b0;
      end else begin
        unique case (state)
          IDLE: state <= INSTR;
          INSTR: if (rise) begin
            hold <= i_sqi_sio;
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd1) begin
              cnt   <= 2'd0;
              is_rd <= instr == SQI_INSTR_READ;
              if (instr == SQI_INSTR_READ || instr == SQI_INSTR_WRITE)
                state <= ADDR;
              else
                state <= IGNORE;
            end
          end
          ADDR: if (rise) begin
            addr <= addr_shift;
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              cnt   <= 2'd0;
              state <= is_rd ? DUMMY : WR_DATA;
            end
          end
          DUMMY: begin
            if (rise) begin
              cnt <= cnt + 2'd1;
            end else if (fall && cnt == 2'd2) begin
              o_sqi_sio    <= ram_rdata[7:4];
              o_sqi_sio_oe <= 1'b1;
              cnt          <= 2'd1;
              state        <= RD_DATA;
            end
          end
          // cnt[0] set: the low nibble is next to go out
          RD_DATA: if (fall) begin
            if (cnt[0]) begin
              o_sqi_sio <= ram_rdata[3:0];
              addr      <= 16'(ptr_inc);
              cnt       <= 2'd0;
            end else begin
              o_sqi_sio <= ram_rdata[7:4];
              cnt       <= 2'd1;
            end
          end
          WR_DATA: if (rise) begin
            if (cnt[0]) begin
              addr <= 16'(ptr_inc);
              cnt  <= 2'd0;
            end else begin
              hold <= i_sqi_sio;
              cnt  <= 2'd1;
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idli_sqi_sram_m.sv
// Directed self-checking bench for the SQI SRAM responder.
module tb_idli_sqi_sram_m;
  import idli_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   sck = 1'b0;
  logic   cs  = 1'b1;
  slice_t sio_in = 4'h0;
  slice_t sio_out;
  logic   oe;

  int passed = 0;
  int total  = 0;

  idli_sqi_sram_m #(.ADDR_W(16), .INIT_FILE("")) dut (
    .i_sqi_gck    (clk),
    .i_sqi_rst    (rst),
    .i_sqi_sck    (sck),
    .i_sqi_cs     (cs),
    .i_sqi_sio    (sio_in),
    .o_sqi_sio    (sio_out),
    .o_sqi_sio_oe (oe)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input slice_t v);
    sio_in = v;
    sck = 1'b1;
    tick(2);
    sck = 1'b0;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    pulse(b[7:4]);
    pulse(b[3:0]);
  endtask

  task automatic begin_cmd(input logic [7:0] ins, input logic [15:0] a);
    cs = 1'b0;
    tick(1);
    send_byte(ins);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic end_cmd();
    cs = 1'b1;
    tick(2);
  endtask

  // Leaves the bus with the high nibble of the first byte driven
  task automatic rd_start(input logic [15:0] a);
    begin_cmd(8'h03, a);
    pulse(4'h0);
    pulse(4'h0);
  endtask

  task automatic rd_byte(output logic [7:0] b);
    b[7:4] = sio_out;
    pulse(4'h0);
    b[3:0] = sio_out;
    pulse(4'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cs  = 1'b1;
    tick(3);
    total++;
    if (oe !== 1'b0 || sio_out !== 4'h0) begin
      $display("FAIL reset_out: oe=%b sio=%h required oe=0 sio=0", oe, sio_out);
    end else passed++;
    total++;
    if (dut.state !== IDLE) begin
      $display("FAIL reset_state: state=%0d required IDLE", dut.state);
    end else passed++;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_write_read();
    logic [7:0] b;
    begin_cmd(8'h02, 16'h1234);
    send_byte(8'hA5);
    send_byte(8'h3C);
    end_cmd();
    begin_cmd(8'h03, 16'h1234);
    pulse(4'h0);
    total++;
    if (oe !== 1'b0) begin
      $display("FAIL dummy_oe: oe=%b required 0", oe);
    end else passed++;
    pulse(4'h0);
    total++;
    if (oe !== 1'b1 || sio_out !== 4'hA) begin
      $display("FAIL first_nibble: oe=%b sio=%h required oe=1 sio=a", oe, sio_out);
    end else passed++;
    rd_byte(b);
    total++;
    if (b !== 8'hA5) begin
      $display("FAIL rd_byte0: got %h required a5", b);
    end else passed++;
    rd_byte(b);
    total++;
    if (b !== 8'h3C || oe !== 1'b1) begin
      $display("FAIL rd_byte1: got %h oe=%b required 3c oe=1", b, oe);
    end else passed++;
    end_cmd();
    total++;
    if (oe !== 1'b0) begin
      $display("FAIL cs_oe: oe=%b required 0", oe);
    end else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    begin_cmd(8'h02, 16'hFFFE);
    send_byte(8'h99);
    end_cmd();
    begin_cmd(8'h02, 16'hFFFF);
    send_byte(8'h11);
    send_byte(8'h22);
    end_cmd();
    rd_start(16'hFFFE);
    rd_byte(b);
    total++;
    if (b !== 8'h99) begin
      $display("FAIL wrap_fffe: got %h required 99", b);
    end else passed++;
    rd_byte(b);
    total++;
    if (b !== 8'h11) begin
      $display("FAIL wrap_ffff: got %h required 11", b);
    end else passed++;
    rd_byte(b);
    total++;
    if (b !== 8'h22) begin
      $display("FAIL wrap_0000: got %h required 22", b);
    end else passed++;
    end_cmd();
  endtask

  task automatic test_ignore();
    logic [7:0] b;
    logic       bad;
    slice_t     junk [8];
    junk = '{4'h0, 4'h0, 4'h4, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
    begin_cmd(8'h02, 16'h0040);
    send_byte(8'h5A);
    end_cmd();
    cs = 1'b0;
    tick(1);
    send_byte(8'h05);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pulse(junk[i]);
      if (oe !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad !== 1'b0) begin
      $display("FAIL ignore_oe: oe went high, required 0");
    end else passed++;
    end_cmd();
    rd_start(16'h0040);
    rd_byte(b);
    total++;
    if (b !== 8'h5A) begin
      $display("FAIL ignore_mem: got %h required 5a", b);
    end else passed++;
    end_cmd();
  endtask

  task automatic test_partial();
    logic [7:0] b;
    begin_cmd(8'h02, 16'h0010);
    send_byte(8'h81);
    end_cmd();
    begin_cmd(8'h02, 16'h0010);
    pulse(4'h7);
    end_cmd();
    rd_start(16'h0010);
    rd_byte(b);
    total++;
    if (b !== 8'h81) begin
      $display("FAIL partial: got %h required 81", b);
    end else passed++;
    end_cmd();
  endtask

  task automatic test_stall();
    logic bad;
    rd_start(16'h1234);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (sio_out !== 4'hA || oe !== 1'b1) bad = 1'b1;
    end
    total++;
    if (bad !== 1'b0) begin
      $display("FAIL stall_hold: sio=%h required a held", sio_out);
    end else passed++;
    pulse(4'h0);
    total++;
    if (sio_out !== 4'h5) begin
      $display("FAIL stall_lo: sio=%h required 5", sio_out);
    end else passed++;
    pulse(4'h0);
    total++;
    if (sio_out !== 4'h3) begin
      $display("FAIL stall_next: sio=%h required 3", sio_out);
    end else passed++;
    end_cmd();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    rd_start(16'h1234);
    total++;
    if (oe !== 1'b1) begin
      $display("FAIL mid_pre_oe: oe=%b required 1", oe);
    end else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (oe !== 1'b0 || sio_out !== 4'h0 || dut.state !== IDLE) begin
      $display("FAIL mid_reset: oe=%b sio=%h state=%0d required 0 0 IDLE",
               oe, sio_out, dut.state);
    end else passed++;
    cs = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    rd_start(16'h0010);
    rd_byte(b);
    total++;
    if (b !== 8'h81) begin
      $display("FAIL post_reset_rd: got %h required 81", b);
    end else passed++;
    end_cmd();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_ignore();
    test_partial();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
